// File: rtl/signal_ext_defs.sv
// Constants shared by the immediate sign extender and narrower.
// OP_SE encodings, field widths, saturation limits, fit helper.
package signal_ext_defs;

    localparam logic SE_IMM12 = 1'b0;
    localparam logic SE_IMM16 = 1'b1;

    localparam int IMM12_W = 12;
    localparam int IMM16_W = 16;
    localparam int DATA_W  = 32;
    localparam int FIELD_W = 16;

    localparam logic [FIELD_W-1:0] SAT12_MAX = 16'h07FF;
    localparam logic [FIELD_W-1:0] SAT12_MIN = 16'hF800;
    localparam logic [FIELD_W-1:0] SAT16_MAX = 16'h7FFF;
    localparam logic [FIELD_W-1:0] SAT16_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_EMPTY        = 2'd0,
        ST_OUT_ONLY     = 2'd1,
        ST_OUT_AND_SKID = 2'd2
    } narrow_state_e;

    typedef struct packed {
        logic                ovf;
        logic [FIELD_W-1:0]  data;
    } narrow_res_t;

    // A value fits when every bit above the field's sign bit
    // matches that sign bit.
    function automatic logic fits_field(
        input logic [DATA_W-1:0] v,
        input logic              op
    );
        logic [20:0] hi12;
        logic [16:0] hi16;
        hi12 = v[31:11];
        hi16 = v[31:15];
        if (op == SE_IMM16) begin
            return (&hi16) || !(|hi16);
        end
        return (&hi12) || !(|hi12);
    endfunction

endpackage

// File: rtl/narrow_check.sv
// Combinational fit check and truncate/saturate of one value.
// SIGNAL_NARROWER_SAT_EN selects saturation of overflows.
module narrow_check
    import signal_ext_defs::*;
(
    input  logic [DATA_W-1:0]  din,
    input  logic               op_se,
    output narrow_res_t        res
);

    logic               fit;
    logic [FIELD_W-1:0] trunc;
`ifdef SIGNAL_NARROWER_SAT_EN
    logic [FIELD_W-1:0] sat;
`endif

    always_comb begin
        fit = fits_field(din, op_se);
        if (op_se == SE_IMM16) begin
            trunc = din[15:0];
        end else begin
            trunc = {{(FIELD_W-IMM12_W){din[11]}}, din[11:0]};
        end
    end

`ifdef SIGNAL_NARROWER_SAT_EN
    // Direction of saturation follows the sign of the full value.
    always_comb begin
        if (op_se == SE_IMM16) begin
            sat = din[31] ? SAT16_MIN : SAT16_MAX;
        end else begin
            sat = din[31] ? SAT12_MIN : SAT12_MAX;
        end
    end

    always_comb begin
        res.ovf  = !fit;
        res.data = fit ? trunc : sat;
    end
`else
    always_comb begin
        res.ovf  = !fit;
        res.data = trunc;
    end
`endif

endmodule

// File: rtl/signal_narrower.sv
// Pipelined 32->12/16-bit signed narrower with skid buffer.
// Overflow handling set by SIGNAL_NARROWER_SAT_EN in narrow_check.
module signal_narrower
    import signal_ext_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in,
    input  logic                OP_SE,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FIELD_W-1:0]  out,
    output logic                ovf,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    narrow_state_e      state_q;
    narrow_state_e      state_d;
    narrow_res_t        out_q;
    narrow_res_t        out_d;
    narrow_res_t        skid_q;
    narrow_res_t        skid_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    narrow_res_t        nc_res;
    logic               accept;
    logic               drain;

    narrow_check u_check (
        .din   (in),
        .op_se (OP_SE),
        .res   (nc_res)
    );

    // in_ready comes straight from state, never from out_ready.
    assign in_ready  = (state_q != ST_OUT_AND_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign out       = out_q.data;
    assign ovf       = out_q.ovf;
    assign ovf_count = cnt_q;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = nc_res;
                    state_d = ST_OUT_ONLY;
                end
            end
            ST_OUT_ONLY: begin
                if (accept && drain) begin
                    out_d   = nc_res;
                end else if (accept) begin
                    skid_d  = nc_res;
                    state_d = ST_OUT_AND_SKID;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_OUT_AND_SKID: begin
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ST_OUT_ONLY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // A clear in the same cycle as an overflowing accept wins.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && nc_res.ovf && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_signal_narrower.sv
// Bench for signal_narrower: queue-based reference model,
// directed literal checks and randomized traffic.
module tb_signal_narrower;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din;
    logic        op_se;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        ovf;
    logic        cnt_clr;
    logic [15:0] ovf_count;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [16:0] q[$];
    int unsigned cnt_m = 0;
    bit          m_acc;
    bit          m_drn;
    logic [16:0] m_res;

    signal_narrower #(.CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .OP_SE     (op_se),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .ovf       (ovf),
        .cnt_clr   (cnt_clr),
        .ovf_count (ovf_count)
    );

    always #5 clock = ~clock;

    // Reference: {ovf, field} from signed range arithmetic.
    function automatic logic [16:0] ref_narrow(logic [31:0] v, logic op);
        longint s;
        longint lo;
        longint hi;
        longint m;
        longint t;
        logic [15:0] r;
        bit fit;
        s  = $signed(v);
        lo = op ? -32768 : -2048;
        hi = op ? 32767 : 2047;
        m  = op ? 65536 : 4096;
        fit = (s >= lo) && (s <= hi);
        if (fit) begin
            r = 16'(s);
        end else begin
`ifdef SIGNAL_NARROWER_SAT_EN
            r = (s > hi) ? 16'(hi) : 16'(lo);
`else
            t = s % m;
            if (t < 0) t = t + m;
            if (t >= m / 2) t = t - m;
            r = 16'(t);
`endif
        end
        return {!fit, r};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            cnt_m = 0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_drn = (q.size() > 0) && out_ready;
            m_res = ref_narrow(din, op_se);
            if (m_drn) void'(q.pop_front());
            if (m_acc) q.push_back(m_res);
            if (cnt_clr) cnt_m = 0;
            else if (m_acc && m_res[16] && cnt_m != 32'hFFFF) cnt_m++;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("ovf_count", {16'd0, ovf_count}, cnt_m);
            if (q.size() > 0) begin
                chk("out", {16'd0, dout}, {16'd0, q[0][15:0]});
                chk("ovf", {31'd0, ovf}, {31'd0, q[0][16]});
            end
        end
    end

    task automatic go(logic [31:0] v, logic op, logic iv,
                      logic ordy, logic clr);
        din       = v;
        op_se     = op;
        in_valid  = iv;
        out_ready = ordy;
        cnt_clr   = clr;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0: return r;
            1: return {{20{r[11]}}, r[11:0]};
            2: return {{16{r[15]}}, r[15:0]};
            3: return 32'h0000_0800 - 32'($urandom_range(0, 2));
            4: return 32'hFFFF_8000 + 32'($urandom_range(0, 2)) - 32'd1;
            default: return {{19{r[12]}}, r[12:0]};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        din = '0;
        op_se = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out", {16'd0, dout}, 32'd0);
        chk("rst ovf", {31'd0, ovf}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst count", {16'd0, ovf_count}, 32'd0);

        go(32'hFFFF_F800, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("min12 out", {16'd0, dout}, 32'hF800);
        chk("min12 ovf", {31'd0, ovf}, 32'd0);
        go(32'h0000_07FF, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("max12 out", {16'd0, dout}, 32'h07FF);
        chk("max12 ovf", {31'd0, ovf}, 32'd0);
        go(32'h0000_0800, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ovf12 ovf", {31'd0, ovf}, 32'd1);
`ifdef SIGNAL_NARROWER_SAT_EN
        chk("ovf12 out", {16'd0, dout}, 32'h07FF);
`else
        chk("ovf12 out", {16'd0, dout}, 32'hF800);
`endif
        chk("ovf12 count", {16'd0, ovf_count}, 32'd1);
        go(32'hFFFF_7FFF, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("ovf16 ovf", {31'd0, ovf}, 32'd1);
`ifdef SIGNAL_NARROWER_SAT_EN
        chk("ovf16 out", {16'd0, dout}, 32'h8000);
`else
        chk("ovf16 out", {16'd0, dout}, 32'h7FFF);
`endif
        go(32'hFFFF_8000, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("min16 out", {16'd0, dout}, 32'h8000);
        chk("min16 ovf", {31'd0, ovf}, 32'd0);
        go(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drained", {31'd0, out_valid}, 32'd0);

        go(32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp1 in_ready", {31'd0, in_ready}, 32'd1);
        go(32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp2 in_ready", {31'd0, in_ready}, 32'd0);
        go(32'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp3 out", {16'd0, dout}, 32'd1);
        chk("bp3 in_ready", {31'd0, in_ready}, 32'd0);
        go(32'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bp4 out", {16'd0, dout}, 32'd2);
        chk("bp4 in_ready", {31'd0, in_ready}, 32'd1);
        go(32'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bp5 out", {16'd0, dout}, 32'd3);
        go(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp done", {31'd0, out_valid}, 32'd0);

        go(32'h0000_0800, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr wins", {16'd0, ovf_count}, 32'd0);
        din = 32'h0000_0800;
        op_se = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        repeat (65535) @(posedge clock);
        @(negedge clock);
        chk("cnt full", {16'd0, ovf_count}, 32'hFFFF);
        go(32'h0000_0800, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("cnt sat", {16'd0, ovf_count}, 32'hFFFF);
        go(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("cnt clr", {16'd0, ovf_count}, 32'd0);

        go(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        go(32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        go(32'h0001_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        go(32'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid rst count", {16'd0, ovf_count}, 32'd0);
        repeat (3) go(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("no stale", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            go(rnd_val(), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 49) == 0));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
